// File: rtl/hdc_pkg.sv
// Shared constants and FSM state type for the HDC class-vector store.
package hdc_pkg;

  localparam int unsigned HDC_NUM_CLASSES = 8;
  localparam int unsigned HDC_NUM_FRAMES  = 3;
  localparam int unsigned HDC_FRAME_W     = 64;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_e;

  function automatic logic in_range(input int unsigned idx, input int unsigned limit);
    return idx < limit;
  endfunction

endpackage

// File: rtl/class_hvec_mem.sv
// Class hypervector register array: one write port, one combinational read
// port, plus a per-class loaded flag with synchronous clear.
module class_hvec_mem
  import hdc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = HDC_NUM_CLASSES,
  parameter int unsigned NUM_FRAMES  = HDC_NUM_FRAMES,
  parameter int unsigned FRAME_W     = HDC_FRAME_W,
  localparam int unsigned CLASS_W     = $clog2(NUM_CLASSES),
  localparam int unsigned FRAME_IDX_W = $clog2(NUM_FRAMES)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   wr_en_i,
  input  logic [CLASS_W-1:0]     wr_class_i,
  input  logic [FRAME_IDX_W-1:0] wr_frame_i,
  input  logic [FRAME_W-1:0]     wr_data_i,
  input  logic [CLASS_W-1:0]     rd_class_i,
  input  logic [FRAME_IDX_W-1:0] rd_frame_i,
  output logic [FRAME_W-1:0]     rd_data_o,
  output logic                   rd_loaded_o
);

  logic [FRAME_W-1:0]     mem_q [NUM_CLASSES][NUM_FRAMES];
  logic [NUM_CLASSES-1:0] loaded_q;
  logic [NUM_CLASSES-1:0] loaded_d;
  logic                   wr_ok;
  logic                   rd_ok;

  assign wr_ok = wr_en_i
              && in_range(32'(wr_class_i), NUM_CLASSES)
              && in_range(32'(wr_frame_i), NUM_FRAMES);

  assign rd_ok = in_range(32'(rd_class_i), NUM_CLASSES)
              && in_range(32'(rd_frame_i), NUM_FRAMES);

  // Contents are deliberately not reset; only the loaded flags are.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_class_i][wr_frame_i] <= wr_data_i;
    end
  end

  // A write in the same cycle as clear keeps its class marked loaded.
  always_comb begin
    loaded_d = clear_i ? '0 : loaded_q;
    if (wr_ok) begin
      loaded_d[wr_class_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loaded_q <= '0;
    end else begin
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    rd_data_o   = '0;
    rd_loaded_o = 1'b0;
    if (rd_ok) begin
      rd_data_o   = mem_q[rd_class_i][rd_frame_i];
      rd_loaded_o = loaded_q[rd_class_i];
    end
  end

endmodule

// File: rtl/class_hvec_store.sv
// Writable class hypervector store; streams one class or a sweep of all
// classes frame by frame over a valid/ready output register.
module class_hvec_store
  import hdc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = HDC_NUM_CLASSES,
  parameter int unsigned NUM_FRAMES  = HDC_NUM_FRAMES,
  parameter int unsigned FRAME_W     = HDC_FRAME_W,
  localparam int unsigned CLASS_W     = $clog2(NUM_CLASSES),
  localparam int unsigned FRAME_IDX_W = $clog2(NUM_FRAMES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [CLASS_W-1:0]     wr_class,
  input  logic [FRAME_IDX_W-1:0] wr_frame,
  input  logic [FRAME_W-1:0]     wr_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CLASS_W-1:0]     req_class,
  input  logic                   req_all,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAME_W-1:0]     out_data,
  output logic [CLASS_W-1:0]     out_class,
  output logic [FRAME_IDX_W-1:0] out_frame,
  output logic                   out_last_frame,
  output logic                   out_last,
  output logic                   out_unloaded,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [CLASS_W-1:0]     cls_q, cls_d;
  logic [FRAME_IDX_W-1:0] frm_q, frm_d;
  logic                   all_q, all_d;

  logic                   ov_q, ov_d;
  logic [FRAME_W-1:0]     od_q, od_d;
  logic [CLASS_W-1:0]     ocls_q, ocls_d;
  logic [FRAME_IDX_W-1:0] ofrm_q, ofrm_d;
  logic                   olf_q, olf_d;
  logic                   olast_q, olast_d;
  logic                   ounl_q, ounl_d;

  logic [FRAME_W-1:0]     rd_data;
  logic                   rd_loaded;
  logic                   accept;
  logic                   load_beat;
  logic                   last_frm;
  logic                   last_cls;
  logic                   beat_last;

  class_hvec_mem #(
    .NUM_CLASSES (NUM_CLASSES),
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_W     (FRAME_W)
  ) u_mem (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .wr_en_i     (wr_en),
    .wr_class_i  (wr_class),
    .wr_frame_i  (wr_frame),
    .wr_data_i   (wr_data),
    .rd_class_i  (cls_q),
    .rd_frame_i  (frm_q),
    .rd_data_o   (rd_data),
    .rd_loaded_o (rd_loaded)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;
  assign load_beat = (state_q == STREAM) && (!ov_q || out_ready);
  assign last_frm  = (frm_q == FRAME_IDX_W'(NUM_FRAMES - 1));
  assign last_cls  = (cls_q == CLASS_W'(NUM_CLASSES - 1));
  assign beat_last = last_frm && (!all_q || last_cls);

  assign out_valid      = ov_q;
  assign out_data       = od_q;
  assign out_class      = ocls_q;
  assign out_frame      = ofrm_q;
  assign out_last_frame = olf_q;
  assign out_last       = olast_q;
  assign out_unloaded   = ounl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cls_q   <= '0;
      frm_q   <= '0;
      all_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ocls_q  <= '0;
      ofrm_q  <= '0;
      olf_q   <= 1'b0;
      olast_q <= 1'b0;
      ounl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      frm_q   <= frm_d;
      all_q   <= all_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ocls_q  <= ocls_d;
      ofrm_q  <= ofrm_d;
      olf_q   <= olf_d;
      olast_q <= olast_d;
      ounl_q  <= ounl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (load_beat && beat_last) state_d = DRAIN;
      DRAIN:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cls_d   = cls_q;
    frm_d   = frm_q;
    all_d   = all_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ocls_d  = ocls_q;
    ofrm_d  = ofrm_q;
    olf_d   = olf_q;
    olast_d = olast_q;
    ounl_d  = ounl_q;

    if (accept) begin
      cls_d = req_all ? '0 : req_class;
      frm_d = '0;
      all_d = req_all;
    end

    // The read is combinational from the pre-edge array, so a same-cycle
    // write to this entry lands after the beat has captured the old value.
    if (load_beat) begin
      ov_d    = 1'b1;
      od_d    = rd_loaded ? rd_data : '0;
      ocls_d  = cls_q;
      ofrm_d  = frm_q;
      olf_d   = last_frm;
      olast_d = beat_last;
      ounl_d  = !rd_loaded;
      if (last_frm) begin
        frm_d = '0;
        if (all_q) begin
          cls_d = cls_q + CLASS_W'(1);
        end
      end else begin
        frm_d = frm_q + FRAME_IDX_W'(1);
      end
    end

    if ((state_q == DRAIN) && out_ready) begin
      ov_d = 1'b0;
    end
  end

endmodule
